present_key_sched_seq: RTL

Sequential, parametrised PRESENT-style key-schedule engine. It generates the round keys one per cycle over a valid/ready stream, and feeds the round-key input of the iterative cipher datapath. It generalises the combinational single-step schedule in three ways: key size is a parameter, it iterates all rounds itself, and it adds an inverse (decrypt-order) mode that regenerates the round keys in reverse from the final key state.

---
 rtl/present_key_sched_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/present_key_sched_seq.sv
// PRESENT-style key schedule engine: emits NUM_ROUNDS+1 round keys over a valid/ready stream,
// in forward (encrypt) order or regenerated in reverse (decrypt) order from the final key state.
module present_key_sched_seq #(
  parameter int unsigned KEY_SIZE   = 80,
  parameter int unsigned NUM_ROUNDS = 31,
  parameter int unsigned RK_WIDTH   = 64,
  parameter int unsigned RW         = $clog2(NUM_ROUNDS + 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dir,
  input  logic [KEY_SIZE-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [RK_WIDTH-1:0] rk,
  output logic [RW-1:0]       rk_round,
  output logic                done,
  output logic [KEY_SIZE-1:0] final_key
);

  if (!(KEY_SIZE == 80 || KEY_SIZE == 128)) begin : gen_bad_key_size
    $error("present_key_sched_seq: KEY_SIZE must be 80 or 128");
  end
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : gen_bad_num_rounds
    $error("present_key_sched_seq: NUM_ROUNDS must be in 1..31");
  end

  localparam int unsigned XorLo      = (KEY_SIZE == 128) ? 62 : 15;
  localparam bit          TwoNibbles = (KEY_SIZE == 128);
  // Nibble i of each table holds S(i) / S^-1(i).
  localparam logic [63:0] SboxTab    = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] SboxInvTab = 64'hA970_364B_D21C_8FE5;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [KEY_SIZE-1:0] final_q, final_d;
  logic [RW-1:0]       round_q, round_d;
  logic                dir_q, dir_d;
  logic                last;
  logic [4:0]          c_fwd, c_inv;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SboxTab[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    return SboxInvTab[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [KEY_SIZE-1:0] fwd_update(input logic [KEY_SIZE-1:0] k,
                                                     input logic [4:0]          c);
    logic [KEY_SIZE-1:0] r;
    r = {k[KEY_SIZE-62:0], k[KEY_SIZE-1:KEY_SIZE-61]};
    r[KEY_SIZE-1 -: 4] = sbox(r[KEY_SIZE-1 -: 4]);
    if (TwoNibbles) r[KEY_SIZE-5 -: 4] = sbox(r[KEY_SIZE-5 -: 4]);
    r[XorLo +: 5] = r[XorLo +: 5] ^ c;
    return r;
  endfunction

  // Undoes fwd_update step by step in reverse order.
  function automatic logic [KEY_SIZE-1:0] inv_update(input logic [KEY_SIZE-1:0] k,
                                                     input logic [4:0]          c);
    logic [KEY_SIZE-1:0] r;
    r = k;
    r[XorLo +: 5] = r[XorLo +: 5] ^ c;
    r[KEY_SIZE-1 -: 4] = sbox_inv(r[KEY_SIZE-1 -: 4]);
    if (TwoNibbles) r[KEY_SIZE-5 -: 4] = sbox_inv(r[KEY_SIZE-5 -: 4]);
    return {r[60:0], r[KEY_SIZE-1:61]};
  endfunction

  assign last  = dir_q ? (round_q == RW'(1)) : (round_q == RW'(NUM_ROUNDS + 1));
  assign c_fwd = 5'(round_q);
  assign c_inv = 5'(round_q - RW'(1));

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    final_d = final_q;
    round_d = round_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          key_d   = key_in;
          dir_d   = dir;
          round_d = dir ? RW'(NUM_ROUNDS + 1) : RW'(1);
          state_d = StRun;
        end
      end
      StRun: begin
        if (rk_ready) begin
          if (last) begin
            final_d = key_q;
            state_d = StDone;
          end else if (dir_q) begin
            key_d   = inv_update(key_q, c_inv);
            round_d = round_q - RW'(1);
          end else begin
            key_d   = fwd_update(key_q, c_fwd);
            round_d = round_q + RW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      final_q <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      final_q <= final_d;
      round_q <= round_d;
      dir_q   <= dir_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign rk_valid  = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign rk        = key_q[KEY_SIZE-1 -: RK_WIDTH];
  assign rk_round  = round_q;
  assign final_key = final_q;

endmodule
